m_cyclecnt_gen: RTL
===================

// Module: m_cyclecnt_gen
// PURPOSE
//  Parametrised successor of the midgetv cycle-timing block. Times each instruction in an
//  RCW-bit counter rccnt; the ALU adds rccnt to ttime during OpCode fetch. Also holds the core
//  in reset until start has been high STARTWAIT consecutive cycles, and flags a bus-error when
//  an IO access outlives BUSTMO. Muxes ALU input QQ (ADR_O, rccnt, or +3/+4 constant).
//  Adds to the previous generation: sync reset, width/threshold parameters, saturation
//  instead of wrap, and a sticky lost-cycle flag.
// PARAMETERS
//  RCW        6   width of rccnt; legal 2..31
//  STARTWAIT  64  consecutive start-high cycles before corerunning; 0..2**RCW
//  BUSTMO     47  rccnt value at which a pending STB_O becomes a bus-error; 1..2**RCW-2
// PORTS
//  clk          in   1    clock, all state on rising edge
//  rst          in   1    synchronous reset, active high
//  start        in   1    enable: startup qualifier / cycle-count enable
//  sa16         in   1    select rccnt onto QQ and reload rccnt (OpCode fetch)
//  sa17         in   1    when sa16=0: 1 = pass ADR_O, 0 = force QQ[1:0]=2'b11
//  STB_O        in   1    bus strobe, an IO access is outstanding
//  ADR_O        in   32   address / ALU operand
//  QQ           out  32   ALU operand
//  corerunning  out  1    core released; sticky until rst
//  buserror     out  1    one-cycle pulse, IO timeout
//  rcsat        out  1    rccnt is saturated at all-ones
//  lostcyc      out  1    sticky: a saturated rccnt was consumed at reload; cleared by rst only
//  dbg_rccnt    out  RCW  rccnt
// BEHAVIOUR
//  Reset (rst=1 at edge): rccnt=0, corerunning=0, buserror=0, rcsat=0, lostcyc=0. rst
//   dominates every other input, including mid-startup and mid-IO.
//  QQ is combinational, zero latency:
//   - sa16=1: {ADR_O[31:RCW], rccnt}
//   - sa16=0, sa17=1: ADR_O
//   - sa16=0, sa17=0: {ADR_O[31:2], 2'b11}
//  Startup (corerunning=0):
//   - start=0: rccnt<=0.
//   - start=1: rccnt<=rccnt+1; sa16 is ignored.
//   - corerunning<=1 at the edge where start=1 and rccnt==STARTWAIT-1, so corerunning goes high
//     STARTWAIT cycles after start rises. That edge also loads rccnt<=1.
//   - STARTWAIT=0: corerunning<=1 at the first edge with start=1; rccnt<=1.
//   - Any start=0 cycle restarts the wait. buserror, rcsat and lostcyc stay 0.
//  Running (corerunning=1):
//   - start=1, sa16=1: rccnt<=1. If rcsat=1, lostcyc<=1.
//   - start=1, sa16=0: rccnt<=rccnt+1, saturating at 2**RCW-1; no wrap.
//   - start=0, sa16=1: rccnt<=0, i.e. the frozen cycle is not counted. If rcsat=1, lostcyc<=1.
//   - start=0, sa16=0: rccnt holds.
//   - corerunning never falls except by rst.
//  rcsat is registered: it is 1 exactly when rccnt==all-ones.
//  Bus-error:
//   - buserror<=1 for one cycle when corerunning & start & STB_O & ~sa16 & (rccnt==BUSTMO).
//   - Otherwise buserror<=0.
//   - The pulse fires once per access because rccnt advances past BUSTMO. A frozen counter
//     (start=0) never fires.
//   - STB_O dropping in the BUSTMO cycle suppresses the pulse.
//  Simultaneous sa16 & STB_O: the reload wins and there is no bus-error.
//  Widths: rccnt is zero-extended where needed. Comparisons use RCW bits. Any Verilog-2001
//   synthesis is legal; no vendor primitives are required.
// TESTING
//  1 Startup: rst, then start=1 for 63 cycles -> corerunning=0; 64th edge -> corerunning=1,
//    rccnt=1. Same again with start=0 at cycle 30 -> the count restarts and corerunning is
//    delayed by 30.
//  2 Timing: running, sa16=0 for 5 cycles then sa16=1 -> QQ[5:0]=6, ADR_O[31:6] passes
//    through; next rccnt=1.
//  3 Mux: sa16=0, sa17=0, ADR_O=0x1000_0004 -> QQ=0x1000_0007; sa17=1 -> QQ=ADR_O.
//  4 Saturation: running, no sa16 for 80 cycles -> rccnt=63 and rcsat=1, with no wrap;
//    then sa16 -> rccnt=1, lostcyc=1, rcsat=0.
//  5 Bus-error: STB_O=1 held while rccnt counts from 1 -> exactly one buserror pulse, on the
//    cycle after rccnt==47. Repeat with STB_O dropped at rccnt=47 -> no pulse. Repeat with
//    start=0 while rccnt=47 -> no pulse.
//  6 Reset mid-operation: rst at rccnt=20 with STB_O=1 -> all outputs 0 next cycle and the
//    startup wait restarts; also sweep RCW=4, STARTWAIT=0, BUSTMO=10.

Source files
------------

// File: rtl/m_cyclecnt_gen.sv
// rtl/m_cyclecnt_gen.sv - instruction cycle counter, startup hold-off and IO bus timeout
// Times each instruction in rccnt, gates core release on a sustained start, and flags stalled IO.
module m_cyclecnt_gen #(
  parameter int RCW       = 6,
  parameter int STARTWAIT = 64,
  parameter int BUSTMO    = 47
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           sa16,
  input  logic           sa17,
  input  logic           STB_O,
  input  logic [31:0]    ADR_O,
  output logic [31:0]    QQ,
  output logic           corerunning,
  output logic           buserror,
  output logic           rcsat,
  output logic           lostcyc,
  output logic [RCW-1:0] dbg_rccnt
);

  typedef enum logic {S_WAIT, S_RUN} state_t;

  localparam int             SW_LAST_I = (STARTWAIT > 0) ? STARTWAIT - 1 : 0;
  localparam logic [RCW-1:0] SW_LAST   = SW_LAST_I[RCW-1:0];
  localparam logic [RCW-1:0] TMO       = BUSTMO[RCW-1:0];
  localparam logic [RCW-1:0] CNT_ONE   = {{(RCW-1){1'b0}}, 1'b1};
  localparam logic [RCW-1:0] CNT_ONES  = '1;

  state_t         state, state_nxt;
  logic [RCW-1:0] rccnt, rccnt_nxt;
  logic           buserror_q, buserror_nxt;
  logic           rcsat_q, rcsat_nxt;
  logic           lostcyc_q, lostcyc_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_WAIT;
      rccnt      <= '0;
      buserror_q <= 1'b0;
      rcsat_q    <= 1'b0;
      lostcyc_q  <= 1'b0;
    end else begin
      state      <= state_nxt;
      rccnt      <= rccnt_nxt;
      buserror_q <= buserror_nxt;
      rcsat_q    <= rcsat_nxt;
      lostcyc_q  <= lostcyc_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    rccnt_nxt    = rccnt;
    buserror_nxt = 1'b0;
    lostcyc_nxt  = lostcyc_q;
    case (state)
      S_WAIT: begin
        if (!start) begin
          rccnt_nxt = '0;
        end else if ((STARTWAIT == 0) || (rccnt == SW_LAST)) begin
          state_nxt = S_RUN;
          rccnt_nxt = CNT_ONE;
        end else begin
          rccnt_nxt = rccnt + CNT_ONE;
        end
      end
      S_RUN: begin
        // A frozen fetch cycle (start=0) is not counted toward the next instruction.
        if (sa16) begin
          rccnt_nxt = start ? CNT_ONE : '0;
          if (rcsat_q) lostcyc_nxt = 1'b1;
        end else if (start && !rcsat_q) begin
          rccnt_nxt = rccnt + CNT_ONE;
        end
        buserror_nxt = start & STB_O & ~sa16 & (rccnt == TMO);
      end
      default: state_nxt = S_WAIT;
    endcase
    // The startup wait may legally pass through all-ones; saturation only means something once running.
    rcsat_nxt = (state_nxt == S_RUN) && (rccnt_nxt == CNT_ONES);
  end

  always_comb begin
    QQ = ADR_O;
    if (sa16)
      QQ = {ADR_O[31:RCW], rccnt};
    else if (!sa17)
      QQ = {ADR_O[31:2], 2'b11};
  end

  assign corerunning = (state == S_RUN);
  assign buserror    = buserror_q;
  assign rcsat       = rcsat_q;
  assign lostcyc     = lostcyc_q;
  assign dbg_rccnt   = rccnt;

endmodule
